// File: rtl/fetch_decode.sv
// fetch_decode: fetch/decode stage ahead of the register file.
// Owns the PC, a run/halt FSM (IDLE/RUN/DONE) and a saturating retired
// instruction counter. Decode is purely combinational from instr_i and state.
//
// Ports:
//   clk, rst_n          core clock, async active-low reset
//   start               level request to (re)start, honoured in IDLE/DONE
//   instr_i             instruction at pc_o from instruction memory
//   branch_target_i     label register value (regfile regA_o during label_read)
//   condition_bit_i     c0[0] from the register file
//   pc_o                program counter
//   rs1/rs2/rd          register selects
//   label_rs            label register select
//   reg_write, label_write, label_read   register file enables
//   alu_op              opcode while RUN, else 0
//   done                high in DONE
//   instr_count         instructions retired since last accepted start
module fetch_decode #(
  parameter logic [7:0] START_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [8:0]  instr_i,
  input  logic [7:0]  branch_target_i,
  input  logic        condition_bit_i,
  output logic [7:0]  pc_o,
  output logic [2:0]  rs1,
  output logic [2:0]  rs2,
  output logic [2:0]  rd,
  output logic [3:0]  label_rs,
  output logic        reg_write,
  output logic        label_write,
  output logic        label_read,
  output logic [2:0]  alu_op,
  output logic        done,
  output logic [15:0] instr_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [8:0] HALT_INSTR = 9'b111_000000;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] cnt_q, cnt_d;

  logic [2:0] op;
  logic       run;
  logic       lbl_ok;   // label index 0..5; 6 and 7 turn LBL/BR into NOPs
  logic       take_br;

  assign op     = instr_i[8:6];
  assign run    = (state_q == RUN);
  assign lbl_ok = (instr_i[5:4] != 2'b11);
  assign take_br = run && (op == 3'b110) && lbl_ok && condition_bit_i;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= 8'h00;
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = START_PC;
          cnt_d   = 16'h0000;
        end
      end
      RUN: begin
        // HALT retires too, so count it before freezing.
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        if (instr_i == HALT_INSTR) begin
          state_d = DONE;          // PC holds on the HALT address
        end else if (take_br) begin
          pc_d = branch_target_i;
        end else begin
          pc_d = pc_q + 8'd1;      // 8-bit wrap is intended
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / decode logic; everything is 0 outside RUN so a reset mid-cycle
  // kills any falling-edge register file write.
  always_comb begin
    rs1         = 3'd0;
    rs2         = 3'd0;
    rd          = 3'd0;
    label_rs    = 4'd0;
    reg_write   = 1'b0;
    label_write = 1'b0;
    label_read  = 1'b0;
    alu_op      = 3'd0;
    if (run) begin
      alu_op = op;
      case (op)
        3'b000, 3'b001, 3'b010, 3'b011, 3'b100: begin
          rd        = instr_i[5:3];
          rs1       = instr_i[5:3];
          rs2       = instr_i[2:0];
          reg_write = 1'b1;
        end
        3'b101: begin
          if (lbl_ok) begin
            label_write = 1'b1;
            rd          = instr_i[5:3];
            rs1         = instr_i[2:0];
          end
        end
        3'b110: begin
          if (lbl_ok) begin
            label_read = 1'b1;
            label_rs   = {1'b0, instr_i[5:3]};
          end
        end
        default: ;  // 111: HALT or NOP, no enables
      endcase
    end
  end

  assign pc_o        = pc_q;
  assign done        = (state_q == DONE);
  assign instr_count = cnt_q;

endmodule
